// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the signed sequential divider:
//   - div_state_e  : controller states (IDLE / RUN / FIX)
//   - DIV_WIDTH_DEF: default operand width (matches the Booth multiplier)
//   - DIV_LATENCY  : accept-edge to done-edge distance for the default width
//   - DIV_MAX_W    : widest supported operand width
//   - div_abs()    : two's-complement magnitude computed one bit wider than
//                    the operand, so |-2^(W-1)| never overflows
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEF = 4;
    localparam int DIV_LATENCY   = DIV_WIDTH_DEF + 1;
    localparam int DIV_MAX_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Magnitude of a sign-extended value; the extra top bit absorbs the most
    // negative operand so the result is always exact.
    function automatic logic [DIV_MAX_W:0] div_abs(input logic [DIV_MAX_W:0] v);
        logic [DIV_MAX_W:0] r;
        if (v[DIV_MAX_W]) begin
            r = (~v) + {{DIV_MAX_W{1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One combinational restoring-division step on magnitudes.
// Ports:
//   rem_in   [WIDTH-1:0]  current partial remainder (always < dsr_mag)
//   next_bit              next dividend bit shifted in at the bottom
//   dsr_mag  [WIDTH-1:0]  divisor magnitude
//   rem_out  [WIDTH-1:0]  new partial remainder
//   q_bit                 quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] dsr_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;
    logic           unused_diff_s;

    assign shifted_s = {rem_in, next_bit};
    assign diff_s    = shifted_s - {1'b0, dsr_mag};
    // Whenever the trial is kept the difference is below the divisor, so its
    // top bit carries no information.
    assign unused_diff_s = diff_s[WIDTH];

    // Trial subtract: keep the difference when non-negative, else restore.
    always_comb begin
        q_bit   = 1'b0;
        rem_out = shifted_s[WIDTH-1:0];
        if (shifted_s >= {1'b0, dsr_mag}) begin
            q_bit   = 1'b1;
            rem_out = diff_s[WIDTH-1:0];
        end else begin
            q_bit   = 1'b0;
            rem_out = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/signed_seq_divider.sv
// ---------------------------------------------------------------------------
// signed_seq_divider
// Sequential signed restoring divider, one quotient bit per clock, truncating
// (C) semantics. Fixed latency: done pulses WIDTH+1 edges after the accept
// edge, for every operand pair including the special cases.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request, honoured only while busy=0
//   dividend, divisor       signed operands, sampled on the accept edge
//   busy                    operation in flight
//   done                    one-cycle pulse, results valid
//   quotient, remainder     signed results, held until the next accept
//   div_by_zero, overflow   per-result flags
// Build option: define DIV_OVERFLOW_SAT_EN to saturate the quotient of
// -2^(WIDTH-1) / -1 to +2^(WIDTH-1)-1 instead of wrapping.
// ---------------------------------------------------------------------------
module signed_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;       // partial remainder magnitude
    logic [WIDTH-1:0] dvd_r;       // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dsr_r;       // divisor magnitude
    logic [WIDTH-1:0] dividend_r;  // raw dividend, needed for divide-by-zero
    logic             qsign_r;
    logic             rsign_r;
    logic             dz_r;
    logic             ov_r;

    logic [DIV_MAX_W:0] dvd_abs_s;
    logic [DIV_MAX_W:0] dsr_abs_s;
    logic               unused_abs_s;
    logic [WIDTH-1:0]   step_rem_s;
    logic               step_q_s;
    logic [WIDTH-1:0]   fix_q_s;
    logic [WIDTH-1:0]   fix_r_s;

    assign dvd_abs_s = div_abs({{(DIV_MAX_W + 1 - WIDTH){dividend[WIDTH-1]}}, dividend});
    assign dsr_abs_s = div_abs({{(DIV_MAX_W + 1 - WIDTH){divisor[WIDTH-1]}}, divisor});
    // Magnitudes never exceed 2^(WIDTH-1), so the upper bits are always zero.
    assign unused_abs_s = ^{dvd_abs_s[DIV_MAX_W:WIDTH], dsr_abs_s[DIV_MAX_W:WIDTH]};

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_r),
        .next_bit (dvd_r[WIDTH-1]),
        .dsr_mag  (dsr_r),
        .rem_out  (step_rem_s),
        .q_bit    (step_q_s)
    );

    // Sign fix-up and special-case overrides for the final result.
    always_comb begin
        fix_q_s = dvd_r;
        fix_r_s = rem_r;
        if (qsign_r) begin
            fix_q_s = -dvd_r;
        end else begin
            fix_q_s = dvd_r;
        end
        if (rsign_r) begin
            fix_r_s = -rem_r;
        end else begin
            fix_r_s = rem_r;
        end
        if (dz_r) begin
            fix_q_s = {WIDTH{1'b1}};
            fix_r_s = dividend_r;
        end else if (ov_r) begin
`ifdef DIV_OVERFLOW_SAT_EN
            fix_q_s = {1'b0, {(WIDTH-1){1'b1}}};
`else
            fix_q_s = {1'b1, {(WIDTH-1){1'b0}}};
`endif
            fix_r_s = {WIDTH{1'b0}};
        end else begin
            fix_q_s = fix_q_s;
            fix_r_s = fix_r_s;
        end
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dsr_r       <= {WIDTH{1'b0}};
            dividend_r  <= {WIDTH{1'b0}};
            qsign_r     <= 1'b0;
            rsign_r     <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rem_r       <= {WIDTH{1'b0}};
                        dvd_r       <= dvd_abs_s[WIDTH-1:0];
                        dsr_r       <= dsr_abs_s[WIDTH-1:0];
                        dividend_r  <= dividend;
                        qsign_r     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rsign_r     <= dividend[WIDTH-1];
                        dz_r        <= (divisor == {WIDTH{1'b0}});
                        ov_r        <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                       (divisor == {WIDTH{1'b1}});
                        cnt_r       <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state_r     <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= step_rem_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    quotient    <= fix_q_s;
                    remainder   <= fix_r_s;
                    div_by_zero <= dz_r;
                    overflow    <= ov_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_signed_seq_divider
// Self-checking bench for signed_seq_divider (WIDTH=4) against a plain
// integer-arithmetic reference model. Honours DIV_OVERFLOW_SAT_EN.
// ---------------------------------------------------------------------------
module tb_signed_seq_divider;
    import div_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_cmp;
    int n_bad;

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: C truncating division on plain ints with the special cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int sa, sb, iq, ir;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = 4'hF;
            r  = a;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
            if (sa == -8 && sb == -1) begin
                ov = 1'b1;
`ifdef DIV_OVERFLOW_SAT_EN
                iq = 7;
`else
                iq = -8;
`endif
                ir = 0;
            end
            q = iq[W-1:0];
            r = ir[W-1:0];
        end
    endtask

    // Counts edges after the accept edge until done is seen (0 = timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int lat);
        logic [W-1:0] eq, er;
        logic edz, eov;
        model(a, b, eq, er, edz, eov);
        chk({tag, "_lat"}, lat, DIV_LATENCY);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, edz);
        chk({tag, "_ov"}, overflow, eov);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom_range(0, 15);
        divisor  = $urandom_range(0, 15);
        chk({tag, "_busy_acc"}, busy, 1'b1);
        wait_done(lat);
        check_result(tag, a, b, lat);
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [7:0] base;
        logic [7:0] p;

        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'h0;
        divisor  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", quotient, 4'h0);
        chk("rst_r", remainder, 4'h0);
        chk("rst_dz", div_by_zero, 1'b0);
        chk("rst_ov", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_op("d7_2", 4'd7, 4'd2);
        do_op("dm7_2", 4'b1001, 4'd2);
        do_op("dm6_7", 4'b1010, 4'd7);
        do_op("d5_0", 4'd5, 4'd0);
        do_op("dm8_m1", 4'b1000, 4'b1111);
        do_op("d7_m2", 4'd7, 4'b1110);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd3; divisor = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check_result("ign", 4'd3, 4'd1, lat);

        // Reset mid-run aborts with no done pulse
        @(negedge clk);
        start = 1'b1; dividend = 4'd7; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_q", quotient, 4'h0);
        chk("abort_r", remainder, 4'h0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort_nodone", pulses, 0);

        // Back-to-back: new start presented in the done cycle
        @(negedge clk);
        start = 1'b1; dividend = 4'b1011; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check_result("b2b_a", 4'b1011, 4'd3, lat);
        start = 1'b1; dividend = 4'd6; divisor = 4'b1100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        wait_done(lat);
        check_result("b2b_b", 4'd6, 4'b1100, lat);

        // All 256 operand pairs in a randomly permuted order
        base = 8'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) begin
            p = 8'(k) ^ base;
            do_op("rnd", p[7:4], p[3:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
Sequential signed restoring divider. It is the inverse-direction companion to the team's combinational Booth multiplier and shares its two's-complement operand widths. Operands are accepted with a start/busy/done handshake and divided with one restoring step per clock. Quotient and remainder follow truncating (C) semantics, and results are registered and held until the next operation.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (signed two's complement); legal range 2..32.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
dividend  in  WIDTH  signed dividend, sampled with start
divisor  in  WIDTH  signed divisor, sampled with start
busy  out  1  high while an operation is in flight
done  out  1  one-cycle pulse when results become valid
quotient  out  WIDTH  signed quotient, held until next accepted start
remainder  out  WIDTH  signed remainder, held until next accepted start
div_by_zero  out  1  sticky-per-result flag: divisor was 0
overflow  out  1  sticky-per-result flag: dividend = -2^(WIDTH-1) and divisor = -1

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, quotient, remainder, div_by_zero, overflow all 0.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1 accepts the request:
  - Latch |dividend|, |divisor|, the quotient sign (sign(dividend) xor sign(divisor)) and the remainder sign (sign(dividend)).
  - Set busy=1, clear done/flags, load the iteration counter with WIDTH, go to RUN.
- RUN: one restoring step per cycle.
  - Shift the {partial_rem, dividend_reg} pair left by 1, then trial-subtract the divisor magnitude (WIDTH+1-bit arithmetic).
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; at 0 go to FIX.
- FIX: apply the signs, truncating to WIDTH.
  - quotient = qsign ? -q_mag : q_mag.
  - remainder = rsign ? -r_mag : r_mag.
  - Register the outputs, pulse done=1 for exactly one cycle, drop busy, go to IDLE.
- Latency: start accepted at edge N → done=1 during the cycle after edge N+WIDTH+1. This is fixed for all operands, including the special cases.
- Absolute value of -2^(WIDTH-1) is computed in WIDTH+1 bits, so there is no internal overflow.
- Divisor = 0: the datapath runs normally for fixed latency. Final outputs are forced to quotient = all ones, remainder = dividend, div_by_zero=1.
- -2^(WIDTH-1) / -1: quotient wraps to -2^(WIDTH-1), remainder = 0, overflow=1.
- start while busy=1: ignored, with no effect on the in-flight operation.
- start in the same cycle done=1: accepted, since the FSM is in IDLE on that edge.
- Operand inputs are don't-care except in the accept cycle.
- rst_n asserted mid-operation aborts immediately to the reset values. No done pulse is produced.

Optional Feature:
Macro DIV_OVERFLOW_SAT_EN.
- Defined: in the -2^(WIDTH-1) / -1 case, quotient saturates to +2^(WIDTH-1)-1, and overflow=1 still asserts.
- Undefined: quotient wraps to -2^(WIDTH-1) as above.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE/RUN/FIX);
  - the default WIDTH constant;
  - the latency constant DIV_LATENCY = WIDTH+1;
  - a helper function for the WIDTH+1-bit absolute value.
- One combinational sub-module, div_restore_step: inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the new partial remainder and the quotient bit.
- The top-level module holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- WIDTH=4, 7 / 2 → quotient=3 (0011), remainder=1 (0001), flags 0. done pulses exactly 5 cycles after the accept edge, for one cycle.
- -7 / 2 and -6 / 7:
  - -7 / 2 → quotient=-3 (1101), remainder=-1 (1111).
  - -6 / 7 → quotient=0, remainder=-6 (1010).
- 5 / 0 → quotient=1111, remainder=0101, div_by_zero=1, overflow=0, same fixed latency.
- -8 / -1:
  - Without the macro → quotient=1000, remainder=0, overflow=1.
  - With DIV_OVERFLOW_SAT_EN → quotient=0111, overflow=1.
- Start 3 / 1, then pulse start with 6 / 2 two cycles later → the second request is ignored and the result is 3 / 0.
- Start 7 / 3, then assert rst_n=0 mid-run → outputs are immediately 0 and no done pulse follows. After release, a back-to-back start on the done cycle is accepted.
- Randomized over all 256 operand pairs vs a reference model → full match.
